// File: rtl/coeff_cfg_ctrl_if.sv
// Frame/read-back bus between the SPI shifter (master) and coeff_cfg_ctrl (slave).
// Write frames travel in on frame_word; read-back data comes out on rd_data.
interface coeff_cfg_ctrl_if;
  logic        frame_valid;
  logic [31:0] frame_word;
  logic        rd_valid;
  logic [23:0] rd_data;

  modport master (
    output frame_valid,
    output frame_word,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  frame_valid,
    input  frame_word,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/coeff_cfg_ctrl.sv
// Coefficient configuration controller: stages SPI writes in a shadow bank and
// copies the whole shadow bank to the active coefficient set on a keyed commit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no half-bank loaded since the last commit or clear
// LOADING  | some, but not all, half-banks loaded
// ARMED    | all eight half-banks loaded; an unforced commit is allowed
// COMMIT   | one cycle; shadow is copied to active on the way out
module coeff_cfg_ctrl #(
  parameter logic [7:0] KEY   = 8'hA5,
  parameter int         ERR_W = 8
) (
  input  logic              SCLK,
  input  logic              reset,
  coeff_cfg_ctrl_if.slave   bus,
  output logic [39:0]       w_cos_1_o,
  output logic [39:0]       w_sin_1_o,
  output logic [39:0]       w_cos_2_o,
  output logic [39:0]       w_sin_2_o,
  output logic              coef_update_o,
  output logic [7:0]        loaded_mask_o,
  output logic [1:0]        state_o,
  output logic [ERR_W-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADING = 2'd1,
    S_ARMED   = 2'd2,
    S_COMMIT  = 2'd3
  } state_e;

  localparam logic [6:0]       ADDR_STATUS = 7'h00;
  localparam logic [6:0]       ADDR_COMMIT = 7'h10;
  localparam logic [6:0]       ADDR_CLEAR  = 7'h11;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e            state_q, state_d;
  logic [7:0][19:0]  shadow_q, shadow_d;
  logic [3:0][39:0]  active_q, active_d;
  logic [7:0]        mask_q, mask_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              coef_update_q, coef_update_d;
  logic              rd_valid_q, rd_valid_d;
  logic [23:0]       rd_data_q, rd_data_d;

  logic              fr_wr;
  logic [6:0]        fr_addr;
  logic [19:0]       fr_data;
  logic [7:0]        fr_key;
  logic              fr_force;
  logic              is_half;
  logic [2:0]        half_idx;
  logic [7:0]        err8;
  logic [ERR_W+7:0]  err_ext;
  logic              unused_nibble;

  assign fr_wr         = bus.frame_word[31];
  assign fr_addr       = bus.frame_word[30:24];
  assign fr_data       = bus.frame_word[23:4];
  assign fr_key        = bus.frame_word[23:16];
  assign fr_force      = bus.frame_word[15];
  assign unused_nibble = ^bus.frame_word[3:0];

  // Half-banks live at 0x01..0x08; addr[2:0]-1 wraps 0x08 onto index 7.
  assign is_half  = (fr_addr >= 7'h01) && (fr_addr <= 7'h08);
  assign half_idx = 3'(fr_addr[2:0] - 3'd1);

  // Status byte carries err_cnt zero-extended or truncated to 8 bits.
  assign err_ext = {8'h00, err_q};
  assign err8    = err_ext[7:0];

  // Shadow halves hold elements MSB-first as written; active packs element k at [5k+4:5k].
  function automatic logic [39:0] pack_bank(input logic [19:0] lo, input logic [19:0] hi);
    logic [39:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      r[5*j +: 5]      = lo[19-5*j -: 5];
      r[20+5*j +: 5]   = hi[19-5*j -: 5];
    end
    return r;
  endfunction

  logic err_inc;
  logic commit_ok;
  logic clear_ok;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    mask_d        = mask_q;
    err_d         = err_q;
    coef_update_d = 1'b0;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    err_inc       = 1'b0;
    commit_ok     = 1'b0;
    clear_ok      = 1'b0;

    // Copy source is the shadow as it stood before any write landing this cycle.
    if (state_q == S_COMMIT) begin
      for (int b = 0; b < 4; b++) begin
        active_d[b] = pack_bank(shadow_q[2*b], shadow_q[2*b+1]);
      end
      coef_update_d = 1'b1;
      mask_d        = '0;
    end

    if (bus.frame_valid) begin
      if (fr_wr) begin
        if (is_half) begin
          shadow_d[half_idx] = fr_data;
          mask_d[half_idx]   = 1'b1;
        end else if (fr_addr == ADDR_COMMIT) begin
          if ((state_q != S_COMMIT) && (fr_key == KEY) &&
              ((mask_q == 8'hFF) || fr_force)) begin
            commit_ok = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end else if (fr_addr == ADDR_CLEAR) begin
          if (state_q == S_COMMIT) begin
            err_inc = 1'b1;
          end else begin
            clear_ok = 1'b1;
            shadow_d = '0;
            mask_d   = '0;
          end
        end else begin
          err_inc = 1'b1;
        end
      end else begin
        rd_valid_d = 1'b1;
        if (is_half) begin
          rd_data_d = {shadow_q[half_idx], 4'b0000};
        end else if (fr_addr == ADDR_STATUS) begin
          rd_data_d = {state_q, 6'b000000, mask_q, err8};
        end else begin
          rd_data_d = '0;
          err_inc   = 1'b1;
        end
      end
    end

    if (clear_ok) begin
      err_d = '0;
    end else if (err_inc && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_W'(1);
    end

    if (commit_ok) begin
      state_d = S_COMMIT;
    end else if (mask_d == 8'h00) begin
      state_d = S_IDLE;
    end else if (mask_d == 8'hFF) begin
      state_d = S_ARMED;
    end else begin
      state_d = S_LOADING;
    end
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      active_q      <= '0;
      mask_q        <= '0;
      err_q         <= '0;
      coef_update_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      mask_q        <= mask_d;
      err_q         <= err_d;
      coef_update_q <= coef_update_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign w_cos_1_o     = active_q[0];
  assign w_sin_1_o     = active_q[1];
  assign w_cos_2_o     = active_q[2];
  assign w_sin_2_o     = active_q[3];
  assign coef_update_o = coef_update_q;
  assign loaded_mask_o = mask_q;
  assign state_o       = state_q;
  assign err_cnt_o     = err_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_coeff_cfg_ctrl.sv
// Self-checking bench for coeff_cfg_ctrl: directed scenarios plus random frames,
// compared every cycle against an element-level reference model.
module tb_coeff_cfg_ctrl;

  logic        SCLK = 1'b0;
  logic        reset;
  logic [39:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic        coef_update;
  logic [7:0]  loaded_mask;
  logic [1:0]  state;
  logic [7:0]  err_cnt;

  coeff_cfg_ctrl_if bus ();

  coeff_cfg_ctrl #(.KEY(8'hA5), .ERR_W(8)) dut (
    .SCLK          (SCLK),
    .reset         (reset),
    .bus           (bus),
    .w_cos_1_o     (w_cos_1),
    .w_sin_1_o     (w_sin_1),
    .w_cos_2_o     (w_cos_2),
    .w_sin_2_o     (w_sin_2),
    .coef_update_o (coef_update),
    .loaded_mask_o (loaded_mask),
    .state_o       (state),
    .err_cnt_o     (err_cnt)
  );

  always #5 SCLK = ~SCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: shadow as sh[half][element-in-half], active as act[bank][element].
  int sh [8][4];
  int act[4][8];
  int m_mask, m_err, m_st, m_rd;
  bit m_upd, m_rv;

  function automatic void model_reset();
    for (int h = 0; h < 8; h++) for (int j = 0; j < 4; j++) sh[h][j] = 0;
    for (int b = 0; b < 4; b++) for (int e = 0; e < 8; e++) act[b][e] = 0;
    m_mask = 0; m_err = 0; m_st = 0; m_rd = 0; m_upd = 0; m_rv = 0;
  endfunction

  function automatic void model_step(input bit fv, input logic [31:0] word);
    int old_st, old_mask, old_err, addr, h, v;
    bit w, err, accepted;
    old_st = m_st; old_mask = m_mask; old_err = m_err;
    err = 0; accepted = 0;
    m_upd = 0; m_rv = 0;
    if (old_st == 3) begin
      for (int b = 0; b < 4; b++)
        for (int e = 0; e < 8; e++) act[b][e] = sh[2*b + e/4][e%4];
      m_upd = 1;
      m_mask = 0;
    end
    if (fv) begin
      w = word[31];
      addr = int'(word[30:24]);
      if (w) begin
        if (addr >= 1 && addr <= 8) begin
          h = addr - 1;
          for (int j = 0; j < 4; j++) sh[h][j] = int'((word[23:4] >> (15 - 5*j)) & 20'h1F);
          m_mask = m_mask | (1 << h);
        end else if (addr == 'h10) begin
          if (old_st != 3 && word[23:16] == 8'hA5 && (old_mask == 255 || word[15])) accepted = 1;
          else err = 1;
        end else if (addr == 'h11) begin
          if (old_st == 3) err = 1;
          else begin
            for (int hh = 0; hh < 8; hh++) for (int j = 0; j < 4; j++) sh[hh][j] = 0;
            m_mask = 0;
            m_err = 0;
          end
        end else err = 1;
      end else begin
        m_rv = 1;
        if (addr >= 1 && addr <= 8) begin
          v = 0;
          for (int j = 0; j < 4; j++) v = v * 32 + sh[addr-1][j];
          m_rd = v * 16;
        end else if (addr == 0) begin
          m_rd = (old_st << 22) | (old_mask << 8) | (old_err & 255);
        end else begin
          m_rd = 0;
          err = 1;
        end
      end
    end
    if (err && m_err < 255) m_err++;
    if (accepted) m_st = 3;
    else if (m_mask == 0) m_st = 0;
    else if (m_mask == 255) m_st = 2;
    else m_st = 1;
  endfunction

  function automatic logic [159:0] model_coefs();
    logic [159:0] v;
    v = '0;
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 8; e++) v[40*b + 5*e +: 5] = 5'(act[b][e]);
    return v;
  endfunction

  task automatic check_all();
    check_eq("coefs",       {w_sin_2, w_cos_2, w_sin_1, w_cos_1}, model_coefs());
    check_eq("coef_update", 160'(coef_update), 160'(m_upd));
    check_eq("rd_valid",    160'(bus.rd_valid), 160'(m_rv));
    check_eq("rd_data",     160'(bus.rd_data), 160'(m_rd));
    check_eq("mask",        160'(loaded_mask), 160'(m_mask));
    check_eq("state",       160'(state), 160'(m_st));
    check_eq("err_cnt",     160'(err_cnt), 160'(m_err));
  endtask

  function automatic logic [31:0] mk(input bit w, input logic [6:0] a, input logic [19:0] d);
    logic [3:0] junk;
    junk = 4'($urandom_range(15));
    return {w, a, d, junk};
  endfunction

  function automatic logic [19:0] half_data(input int a);
    return {5'(a), 5'(a + 1), 5'(a + 2), 5'(a + 3)};
  endfunction

  function automatic logic [19:0] cmt(input logic [7:0] key, input bit frc);
    return {key, frc, 11'b0};
  endfunction

  task automatic cyc(input bit fv, input logic [31:0] word);
    bus.frame_valid = fv;
    bus.frame_word  = word;
    @(posedge SCLK);
    model_step(fv, word);
    @(negedge SCLK);
    check_all();
    bus.frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.frame_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge SCLK);
    @(negedge SCLK);
    check_all();
    check_eq("rst_no_update", 160'(coef_update), 160'd0);
    reset = 1'b0;
  endtask

  initial begin
    int r, a;
    bit w;
    logic [19:0] d;
    bus.frame_valid = 1'b0;
    bus.frame_word  = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge SCLK);
    @(negedge SCLK);
    check_all();
    reset = 1'b0;

    // Status read straight out of reset.
    cyc(1, mk(0, 7'h00, 20'h0));
    check_eq("status_rst", 160'(bus.rd_data), 160'h0);
    cyc(0, '0);

    // Load all halves, then keyed commit.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, mk(1, 7'(i), half_data(i)));
      if (i == 1) check_eq("loading", 160'(state), 160'd1);
    end
    check_eq("mask_full", 160'(loaded_mask), 160'hFF);
    check_eq("armed", 160'(state), 160'd2);
    cyc(1, mk(1, 7'h10, cmt(8'hA5, 1'b0)));
    check_eq("commit_state", 160'(state), 160'd3);
    cyc(0, '0);
    check_eq("update_pulse", 160'(coef_update), 160'd1);
    check_eq("cos1_e0", 160'(w_cos_1[4:0]), 160'd1);
    check_eq("sin2_e7", 160'(w_sin_2[39:35]), 160'd11);
    check_eq("mask_cleared", 160'(loaded_mask), 160'd0);
    cyc(0, '0);
    check_eq("update_once", 160'(coef_update), 160'd0);

    // Partial load: unforced commit rejected, forced commit accepted.
    cyc(1, mk(1, 7'h03, 20'($urandom)));
    cyc(1, mk(1, 7'h10, cmt(8'hA5, 1'b0)));
    check_eq("reject_err", 160'(err_cnt), 160'd1);
    cyc(0, '0);
    cyc(1, mk(1, 7'h10, cmt(8'hA5, 1'b1)));
    cyc(0, '0);
    cyc(1, mk(0, 7'h03, 20'h0));

    // Protocol errors then clear.
    cyc(1, mk(1, 7'h11, 20'h0));
    cyc(1, mk(1, 7'h10, cmt(8'h5A, 1'b1)));
    cyc(1, mk(1, 7'h20, 20'($urandom)));
    cyc(1, mk(0, 7'h10, 20'h0));
    check_eq("err_three", 160'(err_cnt), 160'd3);
    check_eq("bad_read_zero", 160'(bus.rd_data), 160'd0);
    cyc(1, mk(1, 7'h11, 20'h0));
    check_eq("clear_err", 160'(err_cnt), 160'd0);
    check_eq("clear_idle", 160'(state), 160'd0);

    // Write landing during the COMMIT cycle.
    cyc(1, mk(1, 7'h02, 20'($urandom)));
    cyc(1, mk(1, 7'h10, cmt(8'hA5, 1'b1)));
    cyc(1, mk(1, 7'h05, 20'($urandom)));
    check_eq("ovl_mask", 160'(loaded_mask), 160'h10);
    check_eq("ovl_state", 160'(state), 160'd1);
    cyc(0, '0);

    // Reset while in COMMIT aborts the copy.
    cyc(1, mk(1, 7'h10, cmt(8'hA5, 1'b1)));
    do_reset();
    cyc(0, '0);

    // Random back-to-back frames.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(31);
      w = ($urandom_range(9) < 7);
      d = 20'($urandom);
      if (r < 20) a = r % 8 + 1;
      else if (r < 24) begin
        a = 'h10;
        d = cmt(($urandom_range(3) != 0) ? 8'hA5 : 8'($urandom), ($urandom_range(3) == 0));
        w = 1;
      end
      else if (r == 24) a = 'h11;
      else if (r < 28) a = 0;
      else a = $urandom_range(127);
      cyc(($urandom_range(4) != 0), mk(w, 7'(a), d));
    end

    // Error counter saturation.
    cyc(1, mk(1, 7'h11, 20'h0));
    for (int n = 0; n < 260; n++) cyc(1, mk(1, 7'h00, 20'($urandom)));
    check_eq("err_sat", 160'(err_cnt), 160'd255);
    cyc(1, mk(0, 7'h00, 20'h0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
